fifo_word_serializer: RTL and testbench

- Downstream consumer for the circular FIFO. It drains whole words from the FIFO head through the level-sensitive drop interface.
- Each word is split into OUT_WIDTH chunks and emitted on a valid/ready stream, e.g. 32-bit words into bytes for a UART or SPI transmitter.
- Back-to-back words stream with no bubble cycles.

---
 rtl/fifo_word_serializer_if.sv | 24 ++
 rtl/fifo_word_serializer.sv | 92 +++++++++
 tb/tb_fifo_word_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_serializer_if.sv
// FIFO-drain and chunk-stream signals shared by the word serializer and its neighbours.
// master = serializer side; slave = FIFO plus downstream sink.
interface fifo_word_serializer_if #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8
);
   logic                 fifo_empty;
   logic [IN_WIDTH-1:0]  fifo_data;
   logic                 fifo_drop;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_drop, out_data, out_valid, out_last
   );

   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_drop, out_data, out_valid, out_last
   );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops whole words from the FIFO head and emits them as OUT_WIDTH chunks on a
// valid/ready stream, reloading on the last handshake so words stream without bubbles.
module fifo_word_serializer #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   fifo_word_serializer_if.master bus,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_sent
);
   localparam int unsigned CHUNKS = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [IN_WIDTH-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  words_q, words_d;
   logic [IDX_W-1:0]      sel;
   logic                  handshake;
   logic                  last;
   logic                  load;

   always_comb begin
      handshake = (state_q == SEND) && bus.out_ready;
      last      = (state_q == SEND) && (idx_q == LAST_IDX);
      load      = enable && !bus.fifo_empty &&
                  ((state_q == IDLE) || (handshake && last));

      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      words_d = words_q;

      if (handshake && last) begin
         words_d = words_q + CNT_WIDTH'(1);
      end

      // A load on the final handshake takes priority over returning to IDLE.
      if (load) begin
         shift_d = bus.fifo_data;
         idx_d   = '0;
         state_d = SEND;
      end else if (handshake && last) begin
         idx_d   = '0;
         state_d = IDLE;
      end else if (handshake) begin
         idx_d   = idx_q + IDX_W'(1);
      end
   end

   // Output chunk is a pure mux of registered state; no input reaches out_data.
   always_comb begin
      sel          = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
      bus.out_data = '0;
      for (int unsigned i = 0; i < CHUNKS; i++) begin
         if (sel == IDX_W'(i)) begin
            bus.out_data = shift_q[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   assign bus.fifo_drop = load && !rst;
   assign bus.out_valid = (state_q == SEND);
   assign bus.out_last  = last;
   assign busy          = (state_q == SEND);
   assign words_sent    = words_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         words_q <= words_d;
      end
   end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: an LSB-first instance with a 16-bit counter
// and an MSB-first instance with a 4-bit counter, each fed by a small array FIFO.
module tb_fifo_word_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, en0, rst1, en1;
   logic        busy0, busy1;
   logic [15:0] ws0;
   logic [3:0]  ws1;

   int n_cmp = 0;
   int n_err = 0;

   fifo_word_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus0 ();
   fifo_word_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus1 ();

   fifo_word_serializer #(
      .IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0), .CNT_WIDTH(16)
   ) dut0 (
      .clk(clk), .rst(rst0), .enable(en0), .bus(bus0), .busy(busy0), .words_sent(ws0)
   );

   fifo_word_serializer #(
      .IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .CNT_WIDTH(4)
   ) dut1 (
      .clk(clk), .rst(rst1), .enable(en1), .bus(bus1), .busy(busy1), .words_sent(ws1)
   );

   // Array FIFOs: the initial block pushes, the drop strobe pops on the clock edge.
   logic [31:0] mem0 [0:31];
   logic [31:0] mem1 [0:31];
   logic [4:0]  rd0 = '0, wr0 = '0, rd1 = '0, wr1 = '0;

   assign bus0.fifo_empty = (rd0 == wr0);
   assign bus0.fifo_data  = mem0[rd0];
   assign bus1.fifo_empty = (rd1 == wr1);
   assign bus1.fifo_data  = mem1[rd1];

   always @(posedge clk) begin
      if (bus0.fifo_drop) rd0 <= rd0 + 5'd1;
      if (bus1.fifo_drop) rd1 <= rd1 + 5'd1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [31:0] w);
      mem0[wr0] = w;
      wr0 = wr0 + 5'd1;
   endtask

   task automatic push1(input logic [31:0] w);
      mem1[wr1] = w;
      wr1 = wr1 + 5'd1;
   endtask

   // Checks one cycle window (inputs already applied), then advances to the next negedge.
   task automatic obs0(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic dr);
      #1;
      chk({tag, ".valid"}, 64'(bus0.out_valid), 64'(v));
      chk({tag, ".busy"},  64'(busy0),          64'(v));
      chk({tag, ".last"},  64'(bus0.out_last),  64'(l));
      chk({tag, ".drop"},  64'(bus0.fifo_drop), 64'(dr));
      if (v) chk({tag, ".data"}, 64'(bus0.out_data), 64'(d));
      @(negedge clk);
   endtask

   task automatic obs1(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic dr);
      #1;
      chk({tag, ".valid"}, 64'(bus1.out_valid), 64'(v));
      chk({tag, ".busy"},  64'(busy1),          64'(v));
      chk({tag, ".last"},  64'(bus1.out_last),  64'(l));
      chk({tag, ".drop"},  64'(bus1.fifo_drop), 64'(dr));
      if (v) chk({tag, ".data"}, 64'(bus1.out_data), 64'(d));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic done;
      int   c;
      rst0 = 1'b1; rst1 = 1'b1;
      en0  = 1'b0; en1  = 1'b0;
      bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
      @(negedge clk);

      // Reset state; a queued word with enable high must not pop while rst is high.
      push0(32'hA1B2C3D4);
      en0 = 1'b1; bus0.out_ready = 1'b1;
      #1;
      chk("rst.data", 64'(bus0.out_data), 64'h0);
      chk("rst.ws",   64'(ws0),           64'h0);
      chk("rst1.ws",  64'(ws1),           64'h0);
      chk("rst1.valid", 64'(bus1.out_valid), 64'h0);
      obs0("rst", 1'b0, 8'h00, 1'b0, 1'b0);

      // Single word, LSB first
      rst0 = 1'b0;
      obs0("t1.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t1.c0",   1'b1, 8'hD4, 1'b0, 1'b0);
      obs0("t1.c1",   1'b1, 8'hC3, 1'b0, 1'b0);
      obs0("t1.c2",   1'b1, 8'hB2, 1'b0, 1'b0);
      obs0("t1.c3",   1'b1, 8'hA1, 1'b1, 1'b0);
      obs0("t1.idle", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t1.ws", 64'(ws0), 64'd1);

      // Back-to-back words: second pop coincides with the 0x11 handshake
      push0(32'h11223344);
      push0(32'h55667788);
      obs0("t2.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t2.c0",   1'b1, 8'h44, 1'b0, 1'b0);
      obs0("t2.c1",   1'b1, 8'h33, 1'b0, 1'b0);
      obs0("t2.c2",   1'b1, 8'h22, 1'b0, 1'b0);
      obs0("t2.c3",   1'b1, 8'h11, 1'b1, 1'b1);
      obs0("t2.c4",   1'b1, 8'h88, 1'b0, 1'b0);
      obs0("t2.c5",   1'b1, 8'h77, 1'b0, 1'b0);
      obs0("t2.c6",   1'b1, 8'h66, 1'b0, 1'b0);
      obs0("t2.c7",   1'b1, 8'h55, 1'b1, 1'b0);
      obs0("t2.idle", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t2.ws",    64'(ws0),       64'd3);
      chk("t2.count", 64'(wr0 - rd0), 64'd0);

      // Backpressure on C3 for three cycles: seven valid cycles in total
      push0(32'hA1B2C3D4);
      obs0("t3.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t3.c0",   1'b1, 8'hD4, 1'b0, 1'b0);
      bus0.out_ready = 1'b0;
      mem0[rd0 - 5'd1] = 32'hFFFFFFFF;
      obs0("t3.hold0", 1'b1, 8'hC3, 1'b0, 1'b0);
      obs0("t3.hold1", 1'b1, 8'hC3, 1'b0, 1'b0);
      obs0("t3.hold2", 1'b1, 8'hC3, 1'b0, 1'b0);
      bus0.out_ready = 1'b1;
      obs0("t3.c1",   1'b1, 8'hC3, 1'b0, 1'b0);
      obs0("t3.c2",   1'b1, 8'hB2, 1'b0, 1'b0);
      obs0("t3.c3",   1'b1, 8'hA1, 1'b1, 1'b0);
      obs0("t3.idle", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t3.ws", 64'(ws0), 64'd4);

      // enable dropped mid-word: word completes, second word stays queued
      push0(32'h01020304);
      push0(32'h05060708);
      obs0("t5.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t5.c0",   1'b1, 8'h04, 1'b0, 1'b0);
      obs0("t5.c1",   1'b1, 8'h03, 1'b0, 1'b0);
      en0 = 1'b0;
      obs0("t5.c2",   1'b1, 8'h02, 1'b0, 1'b0);
      obs0("t5.c3",   1'b1, 8'h01, 1'b1, 1'b0);
      obs0("t5.off0", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t5.count", 64'(wr0 - rd0), 64'd1);
      obs0("t5.off1", 1'b0, 8'h00, 1'b0, 1'b0);
      en0 = 1'b1;
      obs0("t5.reload", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t5.d0",     1'b1, 8'h08, 1'b0, 1'b0);
      obs0("t5.d1",     1'b1, 8'h07, 1'b0, 1'b0);
      obs0("t5.d2",     1'b1, 8'h06, 1'b0, 1'b0);
      obs0("t5.d3",     1'b1, 8'h05, 1'b1, 1'b0);
      obs0("t5.empty0", 1'b0, 8'h00, 1'b0, 1'b0);
      obs0("t5.empty1", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t5.ws", 64'(ws0), 64'd6);

      // Reset mid-word discards the held word and clears the counter
      push0(32'hDEADBEEF);
      obs0("t6.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs0("t6.c0",   1'b1, 8'hEF, 1'b0, 1'b0);
      obs0("t6.c1",   1'b1, 8'hBE, 1'b0, 1'b0);
      rst0 = 1'b1;
      obs0("t6.rst",  1'b1, 8'hAD, 1'b0, 1'b0);
      rst0 = 1'b0;
      obs0("t6.after", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6.ws", 64'(ws0), 64'd0);

      // MSB-first instance
      push1(32'hA1B2C3D4);
      en1 = 1'b1; bus1.out_ready = 1'b1; rst1 = 1'b0;
      obs1("t4.load", 1'b0, 8'h00, 1'b0, 1'b1);
      obs1("t4.c0",   1'b1, 8'hA1, 1'b0, 1'b0);
      obs1("t4.c1",   1'b1, 8'hB2, 1'b0, 1'b0);
      obs1("t4.c2",   1'b1, 8'hC3, 1'b0, 1'b0);
      obs1("t4.c3",   1'b1, 8'hD4, 1'b1, 1'b0);
      obs1("t4.idle", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t4.ws", 64'(ws1), 64'd1);

      // 16 more words on the 4-bit counter: 17 total wraps to 1
      for (int i = 0; i < 16; i++) push1(32'h01010101 * (i + 1));
      done = 1'b0;
      c = 0;
      while (!done && c < 300) begin
         @(negedge clk);
         c++;
         done = (rd1 == wr1) && !busy1;
      end
      chk("t6.wrap_done", 64'(done), 64'd1);
      chk("t6.wrap_ws",   64'(ws1),  64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
